// File: rtl/gmac_csr_pkg.sv
// Shared register offsets, CTRL field positions and decode helper for the GMAC CSR block.
package gmac_csr_pkg;

    localparam logic [7:0] CSR_CTRL       = 8'h00;
    localparam logic [7:0] CSR_MAC_LO     = 8'h04;
    localparam logic [7:0] CSR_MAC_HI     = 8'h08;
    localparam logic [7:0] CSR_IRQ_STATUS = 8'h0C;
    localparam logic [7:0] CSR_IRQ_MASK   = 8'h10;
    localparam logic [7:0] CSR_VERSION    = 8'h14;
    localparam logic [7:0] CSR_TX_FRAMES  = 8'h18;
    localparam logic [7:0] CSR_RX_FRAMES  = 8'h1C;

    localparam int CTRL_TX_EN       = 0;
    localparam int CTRL_RX_EN       = 1;
    localparam int CTRL_SPEED_LO    = 2;
    localparam int CTRL_SPEED_HI    = 3;
    localparam int CTRL_FULL_DUPLEX = 4;

    localparam logic [31:0] VERSION_DEFAULT = 32'h0002_0000;

    typedef enum logic [3:0] {
        SEL_CTRL,
        SEL_MAC_LO,
        SEL_MAC_HI,
        SEL_STATUS,
        SEL_MASK,
        SEL_VERSION,
        SEL_TX,
        SEL_RX,
        SEL_NONE
    } csr_sel_e;

    // Offset is the word-aligned address within the 32-byte register window.
    function automatic csr_sel_e csr_decode(input logic [4:0] off);
        case ({3'b000, off})
            CSR_CTRL:       return SEL_CTRL;
            CSR_MAC_LO:     return SEL_MAC_LO;
            CSR_MAC_HI:     return SEL_MAC_HI;
            CSR_IRQ_STATUS: return SEL_STATUS;
            CSR_IRQ_MASK:   return SEL_MASK;
            CSR_VERSION:    return SEL_VERSION;
            CSR_TX_FRAMES:  return SEL_TX;
            CSR_RX_FRAMES:  return SEL_RX;
            default:        return SEL_NONE;
        endcase
    endfunction

endpackage

// File: rtl/gmac_csr_sat_cnt.sv
// 32-bit saturating event counter; a clear in the same cycle as an increment wins.
module gmac_csr_sat_cnt (
    input  logic        clk,
    input  logic        rstn,
    input  logic        inc,
    input  logic        clr,
    output logic [31:0] count
);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (count != 32'hFFFF_FFFF)) begin
            count <= count + 32'd1;
        end
    end

endmodule

// File: rtl/gmac_csr_regs.sv
// GMAC configuration/interrupt register block with req/ack bus access.
// Define GMAC_CSR_STATS_EN to build the TX/RX frame statistics counters.
module gmac_csr_regs
    import gmac_csr_pkg::*;
#(
    parameter int          ADDR_W       = 8,
    parameter int          NUM_IRQ      = 4,
    parameter logic [47:0] RST_MAC_ADDR = 48'h001122334455,
    parameter logic [1:0]  RST_SPEED    = 2'b10,
    parameter logic [31:0] VERSION      = VERSION_DEFAULT
) (
    input  logic               sys_clk,
    input  logic               sys_rstn,
    input  logic               csr_req,
    input  logic               csr_we,
    input  logic [ADDR_W-1:0]  csr_addr,
    input  logic [31:0]        csr_wdata,
    output logic               csr_ack,
    output logic [31:0]        csr_rdata,
    output logic               csr_err,
    input  logic [NUM_IRQ-1:0] irq_event,
    output logic               irq,
    input  logic               tx_frame_done,
    input  logic               rx_frame_done,
    output logic               cfg_tx_en,
    output logic               cfg_rx_en,
    output logic [1:0]         cfg_speed,
    output logic               cfg_full_duplex,
    output logic [47:0]        cfg_mac_addr
);

    logic [ADDR_W-1:0]  addr_word;
    logic               in_window;
    csr_sel_e           sel;
    logic               mapped;
    logic               accept;
    logic               wr;
    logic [31:0]        rd_val;
    logic [31:0]        mac_stage;
    logic [NUM_IRQ-1:0] irq_status;
    logic [NUM_IRQ-1:0] irq_mask;
    logic [NUM_IRQ-1:0] status_clr;
    logic               unused_addr_lsb;

    assign unused_addr_lsb = ^csr_addr[1:0];

    assign addr_word = {csr_addr[ADDR_W-1:2], 2'b00};
    assign in_window = addr_word < ADDR_W'(32);
    assign sel       = in_window ? csr_decode(addr_word[4:0]) : SEL_NONE;

`ifdef GMAC_CSR_STATS_EN
    logic [31:0] tx_frames;
    logic [31:0] rx_frames;

    assign mapped = (sel != SEL_NONE);
`else
    logic unused_frame_done;

    assign unused_frame_done = tx_frame_done ^ rx_frame_done;
    assign mapped = (sel != SEL_NONE) && (sel != SEL_TX) && (sel != SEL_RX);
`endif

    // A request still visible during its own ack cycle is the tail of that access.
    assign accept = csr_req && !csr_ack;
    assign wr     = accept && csr_we && mapped;

    always_comb begin
        rd_val = '0;
        case (sel)
            SEL_CTRL: begin
                rd_val[CTRL_TX_EN]                   = cfg_tx_en;
                rd_val[CTRL_RX_EN]                   = cfg_rx_en;
                rd_val[CTRL_SPEED_HI:CTRL_SPEED_LO]  = cfg_speed;
                rd_val[CTRL_FULL_DUPLEX]             = cfg_full_duplex;
            end
            SEL_MAC_LO:  rd_val = cfg_mac_addr[31:0];
            SEL_MAC_HI:  rd_val[15:0] = cfg_mac_addr[47:32];
            SEL_STATUS:  rd_val[NUM_IRQ-1:0] = irq_status;
            SEL_MASK:    rd_val[NUM_IRQ-1:0] = irq_mask;
            SEL_VERSION: rd_val = VERSION;
`ifdef GMAC_CSR_STATS_EN
            SEL_TX:      rd_val = tx_frames;
            SEL_RX:      rd_val = rx_frames;
`endif
            default:     rd_val = '0;
        endcase
    end

    always_ff @(posedge sys_clk or negedge sys_rstn) begin
        if (!sys_rstn) begin
            csr_ack   <= 1'b0;
            csr_err   <= 1'b0;
            csr_rdata <= '0;
        end else begin
            csr_ack   <= accept;
            csr_err   <= accept && !mapped;
            csr_rdata <= (accept && !csr_we && mapped) ? rd_val : '0;
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rstn) begin
        if (!sys_rstn) begin
            cfg_tx_en       <= 1'b1;
            cfg_rx_en       <= 1'b1;
            cfg_speed       <= RST_SPEED;
            cfg_full_duplex <= 1'b1;
            mac_stage       <= RST_MAC_ADDR[31:0];
            cfg_mac_addr    <= RST_MAC_ADDR;
            irq_mask        <= '0;
        end else if (wr) begin
            case (sel)
                SEL_CTRL: begin
                    cfg_tx_en       <= csr_wdata[CTRL_TX_EN];
                    cfg_rx_en       <= csr_wdata[CTRL_RX_EN];
                    cfg_speed       <= csr_wdata[CTRL_SPEED_HI:CTRL_SPEED_LO];
                    cfg_full_duplex <= csr_wdata[CTRL_FULL_DUPLEX];
                end
                SEL_MAC_LO: mac_stage <= csr_wdata;
                // Whole address commits at once so the MAC never sees a half-updated value.
                SEL_MAC_HI: cfg_mac_addr <= {csr_wdata[15:0], mac_stage};
                SEL_MASK:   irq_mask <= csr_wdata[NUM_IRQ-1:0];
                default: ;
            endcase
        end
    end

    assign status_clr = (wr && (sel == SEL_STATUS)) ? csr_wdata[NUM_IRQ-1:0] : '0;

    always_ff @(posedge sys_clk or negedge sys_rstn) begin
        if (!sys_rstn) begin
            irq_status <= '0;
            irq        <= 1'b0;
        end else begin
            irq_status <= (irq_status & ~status_clr) | irq_event;
            irq        <= |(irq_status & irq_mask);
        end
    end

`ifdef GMAC_CSR_STATS_EN
    gmac_csr_sat_cnt u_tx_cnt (
        .clk   (sys_clk),
        .rstn  (sys_rstn),
        .inc   (tx_frame_done),
        .clr   (wr && (sel == SEL_TX)),
        .count (tx_frames)
    );

    gmac_csr_sat_cnt u_rx_cnt (
        .clk   (sys_clk),
        .rstn  (sys_rstn),
        .inc   (rx_frame_done),
        .clr   (wr && (sel == SEL_RX)),
        .count (rx_frames)
    );
`endif

endmodule

// File: tb/tb_gmac_csr_regs.sv
// Randomized bench for gmac_csr_regs against a register-map level reference model.
// Honours GMAC_CSR_STATS_EN the same way the design does.
module tb_gmac_csr_regs;

    logic        sys_clk;
    logic        sys_rstn;
    logic        csr_req;
    logic        csr_we;
    logic [7:0]  csr_addr;
    logic [31:0] csr_wdata;
    logic        csr_ack;
    logic [31:0] csr_rdata;
    logic        csr_err;
    logic [3:0]  irq_event;
    logic        irq;
    logic        tx_frame_done;
    logic        rx_frame_done;
    logic        cfg_tx_en;
    logic        cfg_rx_en;
    logic [1:0]  cfg_speed;
    logic        cfg_full_duplex;
    logic [47:0] cfg_mac_addr;

    gmac_csr_regs dut (
        .sys_clk         (sys_clk),
        .sys_rstn        (sys_rstn),
        .csr_req         (csr_req),
        .csr_we          (csr_we),
        .csr_addr        (csr_addr),
        .csr_wdata       (csr_wdata),
        .csr_ack         (csr_ack),
        .csr_rdata       (csr_rdata),
        .csr_err         (csr_err),
        .irq_event       (irq_event),
        .irq             (irq),
        .tx_frame_done   (tx_frame_done),
        .rx_frame_done   (rx_frame_done),
        .cfg_tx_en       (cfg_tx_en),
        .cfg_rx_en       (cfg_rx_en),
        .cfg_speed       (cfg_speed),
        .cfg_full_duplex (cfg_full_duplex),
        .cfg_mac_addr    (cfg_mac_addr)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: register contents as plain variables, advanced once per clock.
    logic [4:0]  m_ctrl;
    logic [47:0] m_mac;
    logic [31:0] m_stage;
    logic [3:0]  m_status;
    logic [3:0]  m_mask;
    logic        m_irq;
    logic        m_ack;
    logic        m_err;
    logic [31:0] m_rdata;
    logic [31:0] m_txc;
    logic [31:0] m_rxc;

    task automatic model_reset();
        m_ctrl   = 5'h1B;
        m_mac    = 48'h001122334455;
        m_stage  = 32'h22334455;
        m_status = '0;
        m_mask   = '0;
        m_irq    = 1'b0;
        m_ack    = 1'b0;
        m_err    = 1'b0;
        m_rdata  = '0;
        m_txc    = '0;
        m_rxc    = '0;
    endtask

    task automatic model_step();
        bit          acc;
        bit          mapped;
        bit          clr_tx;
        bit          clr_rx;
        int          off;
        logic [31:0] rv;
        logic [3:0]  clr;
        logic        irq_n;
        acc    = csr_req && !m_ack;
        off    = int'(csr_addr) & 32'hFC;
        mapped = 1'b1;
        rv     = '0;
        clr    = '0;
        clr_tx = 1'b0;
        clr_rx = 1'b0;
        case (off)
            'h00: rv = {27'd0, m_ctrl};
            'h04: rv = m_mac[31:0];
            'h08: rv = {16'd0, m_mac[47:32]};
            'h0C: rv = {28'd0, m_status};
            'h10: rv = {28'd0, m_mask};
            'h14: rv = 32'h0002_0000;
`ifdef GMAC_CSR_STATS_EN
            'h18: rv = m_txc;
            'h1C: rv = m_rxc;
`endif
            default: mapped = 1'b0;
        endcase
        irq_n = |(m_status & m_mask);
        if (acc && csr_we && mapped) begin
            case (off)
                'h00: m_ctrl  = csr_wdata[4:0];
                'h04: m_stage = csr_wdata;
                'h08: m_mac   = {csr_wdata[15:0], m_stage};
                'h0C: clr     = csr_wdata[3:0];
                'h10: m_mask  = csr_wdata[3:0];
                'h18: clr_tx  = 1'b1;
                'h1C: clr_rx  = 1'b1;
                default: ;
            endcase
        end
`ifdef GMAC_CSR_STATS_EN
        if (clr_tx) m_txc = '0;
        else if (tx_frame_done && m_txc != 32'hFFFF_FFFF) m_txc = m_txc + 1;
        if (clr_rx) m_rxc = '0;
        else if (rx_frame_done && m_rxc != 32'hFFFF_FFFF) m_rxc = m_rxc + 1;
`endif
        m_status = (m_status & ~clr) | irq_event;
        m_irq    = irq_n;
        m_ack    = acc;
        m_err    = acc && !mapped;
        m_rdata  = (acc && !csr_we && mapped) ? rv : 32'd0;
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge sys_clk or negedge sys_rstn);
            if (!sys_rstn) model_reset();
            else model_step();
        end
    end

    initial begin
        forever begin
            @(negedge sys_clk);
            check("tx_en",  64'(cfg_tx_en),       64'(m_ctrl[0]));
            check("rx_en",  64'(cfg_rx_en),       64'(m_ctrl[1]));
            check("speed",  64'(cfg_speed),       64'(m_ctrl[3:2]));
            check("fdx",    64'(cfg_full_duplex), 64'(m_ctrl[4]));
            check("mac",    64'(cfg_mac_addr),    64'(m_mac));
            check("irq",    64'(irq),             64'(m_irq));
            check("ack",    64'(csr_ack),         64'(m_ack));
            check("err",    64'(csr_err),         64'(m_err));
            check("rdata",  64'(csr_rdata),       64'(m_rdata));
        end
    end

    bit rnd_ev = 1'b0;

    initial begin
        forever begin
            @(negedge sys_clk);
            if (rnd_ev) begin
                irq_event     = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'd0;
                tx_frame_done = ($urandom_range(0, 2) == 0);
                rx_frame_done = ($urandom_range(0, 2) == 0);
            end
        end
    end

    task automatic csr(input bit we, input logic [7:0] a, input logic [31:0] wd,
                       input logic [3:0] ev, output logic [31:0] rd, output logic er);
        bit got;
        got = 1'b0;
        rd  = '0;
        er  = 1'b0;
        @(negedge sys_clk);
        csr_req   = 1'b1;
        csr_we    = we;
        csr_addr  = a;
        csr_wdata = wd;
        if (ev != 0) irq_event = ev;
        for (int i = 0; i < 8 && !got; i++) begin
            @(negedge sys_clk);
            if (ev != 0) irq_event = '0;
            if (csr_ack) begin
                got = 1'b1;
                rd  = csr_rdata;
                er  = csr_err;
            end
        end
        csr_req = 1'b0;
        if (!got) check("ack_timeout", 64'd0, 64'd1);
    endtask

    logic [31:0] rd;
    logic        er;
    int          ack_seen;

    initial begin
        sys_rstn      = 1'b0;
        csr_req       = 1'b0;
        csr_we        = 1'b0;
        csr_addr      = '0;
        csr_wdata     = '0;
        irq_event     = '0;
        tx_frame_done = 1'b0;
        rx_frame_done = 1'b0;
        repeat (3) @(negedge sys_clk);
        sys_rstn = 1'b1;

        csr(0, 8'h00, 0, 0, rd, er);  check("rst_ctrl", 64'(rd), 64'h1B);
        csr(0, 8'h08, 0, 0, rd, er);  check("rst_mac_hi", 64'(rd), 64'h11);
        csr(0, 8'h14, 0, 0, rd, er);  check("version", 64'(rd), 64'h0002_0000);
        check("rst_mac", 64'(cfg_mac_addr), 64'h0000_0011_2233_4455);

        csr(1, 8'h04, 32'hAABBCCDD, 0, rd, er);
        check("mac_staged", 64'(cfg_mac_addr), 64'h0000_0011_2233_4455);
        csr(1, 8'h08, 32'h0000_1234, 0, rd, er);
        check("mac_commit", 64'(cfg_mac_addr), 64'h0000_1234_AABB_CCDD);
        csr(0, 8'h04, 0, 0, rd, er);  check("mac_lo_rd", 64'(rd), 64'hAABBCCDD);

        csr(1, 8'h10, 32'h1, 0, rd, er);
        @(negedge sys_clk);
        irq_event = 4'b0011;
        @(negedge sys_clk);
        irq_event = '0;
        check("irq_n1", 64'(irq), 64'd0);
        @(negedge sys_clk);
        check("irq_n2", 64'(irq), 64'd1);
        csr(0, 8'h0C, 0, 0, rd, er);  check("status", 64'(rd), 64'h3);
        csr(1, 8'h0C, 32'h1, 4'b0001, rd, er);
        csr(0, 8'h0C, 0, 0, rd, er);  check("set_wins", 64'(rd), 64'h3);
        csr(1, 8'h0C, 32'hF, 0, rd, er);
        csr(0, 8'h0C, 0, 0, rd, er);  check("status_clr", 64'(rd), 64'h0);
        check("irq_clr", 64'(irq), 64'd0);

        csr(0, 8'h40, 0, 0, rd, er);
        check("bad_rd_err", 64'(er), 64'd1);
        check("bad_rd_data", 64'(rd), 64'd0);
        csr(1, 8'h40, 32'hFFFF_FFFF, 0, rd, er);
        check("bad_wr_err", 64'(er), 64'd1);
        csr(1, 8'h20, 32'h0, 0, rd, er);
        check("bad_20_err", 64'(er), 64'd1);
        csr(0, 8'h00, 0, 0, rd, er);  check("bad_ctrl", 64'(rd), 64'h1B);
        csr(0, 8'h10, 0, 0, rd, er);  check("bad_mask", 64'(rd), 64'h1);

`ifdef GMAC_CSR_STATS_EN
        @(negedge sys_clk);
        dut.u_tx_cnt.count = 32'hFFFF_FFFE;
        m_txc = 32'hFFFF_FFFE;
        repeat (3) begin
            @(negedge sys_clk);
            tx_frame_done = 1'b1;
            @(negedge sys_clk);
            tx_frame_done = 1'b0;
        end
        csr(0, 8'h18, 0, 0, rd, er);
        check("tx_sat", 64'(rd), 64'hFFFF_FFFF);
        check("tx_sat_err", 64'(er), 64'd0);
        csr(1, 8'h18, 32'h5, 0, rd, er);
        csr(0, 8'h18, 0, 0, rd, er);
        check("tx_clr", 64'(rd), 64'd0);
`else
        csr(0, 8'h18, 0, 0, rd, er);
        check("tx_absent_err", 64'(er), 64'd1);
        csr(0, 8'h1C, 0, 0, rd, er);
        check("rx_absent_err", 64'(er), 64'd1);
`endif

        rnd_ev = 1'b1;
        for (int k = 0; k < 250; k++) begin
            int sel;
            logic [7:0] a;
            sel = $urandom_range(0, 10);
            if (sel == 10) a = 8'h40 | 8'($urandom_range(0, 63));
            else a = 8'(sel * 4 + $urandom_range(0, 3));
            csr(bit'($urandom_range(0, 1)), a, $urandom, 0, rd, er);
            repeat ($urandom_range(0, 2)) @(negedge sys_clk);
        end
        @(negedge sys_clk);
        rnd_ev        = 1'b0;
        irq_event     = '0;
        tx_frame_done = 1'b0;
        rx_frame_done = 1'b0;

        // Reset lands while a CTRL write is pending: no ack, CTRL back to reset value.
        csr(1, 8'h00, 32'h0, 0, rd, er);
        ack_seen = 0;
        @(negedge sys_clk);
        csr_req   = 1'b1;
        csr_we    = 1'b1;
        csr_addr  = 8'h00;
        csr_wdata = 32'h0;
        #1 sys_rstn = 1'b0;
        repeat (2) begin
            @(negedge sys_clk);
            if (csr_ack) ack_seen++;
        end
        csr_req  = 1'b0;
        sys_rstn = 1'b1;
        repeat (2) begin
            @(negedge sys_clk);
            if (csr_ack) ack_seen++;
        end
        check("rst_no_ack", 64'(ack_seen), 64'd0);
        check("rst_tx_en", 64'(cfg_tx_en), 64'd1);
        csr(0, 8'h00, 0, 0, rd, er);  check("rst_mid_ctrl", 64'(rd), 64'h1B);

        @(negedge sys_clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
